// File: rtl/mtm_alu_serializer_fifo.sv
// ============================================================================
// Module   : mtm_alu_serializer_fifo
// Purpose  : FIFO-buffered ALU result serializer emitting 11-bit packets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mtm_alu_serializer_fifo #(
    parameter int N_BYTES = 4,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [8*N_BYTES-1:0]         in_data,
    input  logic [7:0]                   in_ctl,
    input  logic                         in_err,
    output logic                         sout,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int c_DATA_W  = 8 * N_BYTES;
    localparam int c_ENTRY_W = c_DATA_W + 9;
    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_LVL_W   = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;

    state_t               r_state;
    logic [3:0]           r_bit_cnt;
    logic [3:0]           r_byte_cnt;
    logic                 r_err;
    logic [7:0]           r_ctl;
    logic [c_DATA_W-1:0]  r_shift;
    logic                 r_sout;
    logic                 r_busy;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_last;
    logic [7:0]           w_cur_byte;
    logic                 w_bit;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_full     = (r_level == c_LVL_W'(DEPTH));
    assign w_empty    = (r_level == '0);
    assign in_ready   = !rst && !w_full;
    assign w_push     = in_valid && in_ready;
    assign w_head     = r_mem[r_rd_ptr];
    assign fifo_level = r_level;
    assign sout       = r_sout;
    assign busy       = r_busy;

    // An error frame is a single control packet, so it is always "last".
    assign w_last     = r_err || (r_byte_cnt == 4'(N_BYTES));
    assign w_cur_byte = w_last ? r_ctl : r_shift[c_DATA_W-1 -: 8];
    assign w_pop      = !w_empty &&
                        ((r_state == S_IDLE) ||
                         (r_state == S_SEND && r_bit_cnt == 4'd10 && w_last));

    always_comb begin
        w_bit = 1'b1;
        case (r_bit_cnt)
            4'd0:    w_bit = 1'b0;
            4'd1:    w_bit = w_last;
            4'd10:   w_bit = 1'b1;
            default: w_bit = w_cur_byte[3'(4'd9 - r_bit_cnt)];
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_err, in_ctl, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 4'd0;
            r_byte_cnt <= 4'd0;
            r_err      <= 1'b0;
            r_ctl      <= 8'd0;
            r_shift    <= '0;
            r_sout     <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_sout <= 1'b1;
                    if (w_pop) begin
                        {r_err, r_ctl, r_shift} <= w_head;
                        r_bit_cnt  <= 4'd0;
                        r_byte_cnt <= 4'd0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SEND;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_SEND: begin
                    r_sout <= w_bit;
                    r_busy <= 1'b1;
                    if (r_bit_cnt == 4'd10) begin
                        r_bit_cnt <= 4'd0;
                        if (w_last) begin
                            r_byte_cnt <= 4'd0;
                            // Chain the next frame straight after this stop bit.
                            if (w_pop) begin
                                {r_err, r_ctl, r_shift} <= w_head;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 4'd1;
                            r_shift    <= r_shift << 8;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mtm_alu_serializer_fifo.sv
// ============================================================================
// Module   : tb_mtm_alu_serializer_fifo
// Purpose  : Directed self-checking bench for mtm_alu_serializer_fifo.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mtm_alu_serializer_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_err, sout, busy;
    logic [31:0] in_data;
    logic [7:0]  in_ctl;
    logic [2:0]  fifo_level;

    logic        in_valid_b, in_ready_b, in_err_b, sout_b, busy_b;
    logic [7:0]  in_data_b, in_ctl_b;
    logic [1:0]  fifo_level_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mtm_alu_serializer_fifo #(.N_BYTES(4), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctl(in_ctl), .in_err(in_err),
        .sout(sout), .busy(busy), .fifo_level(fifo_level)
    );

    mtm_alu_serializer_fifo #(.N_BYTES(1), .DEPTH(2)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .in_ctl(in_ctl_b), .in_err(in_err_b),
        .sout(sout_b), .busy(busy_b), .fifo_level(fifo_level_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [31:0] d, input logic [7:0] c, input logic e);
        in_valid = 1'b1; in_data = d; in_ctl = c; in_err = e;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic capture(input int n, input bit sel, output logic [63:0] bits);
        bits = '0;
        for (int i = 0; i < n; i++) begin
            tick;
            bits = {bits[62:0], (sel ? sout_b : sout)};
        end
    endtask

    // Protocol model: four data packets MSB byte first, then the control packet.
    function automatic logic [63:0] frame55(input logic [31:0] d, input logic [7:0] c);
        logic [63:0] f = '0;
        for (int b = 0; b < 4; b++)
            f = (f << 11) | {53'd0, 2'b00, d[31-8*b -: 8], 1'b1};
        f = (f << 11) | {53'd0, 2'b01, c, 1'b1};
        return f;
    endfunction

    // Line decoder: each completed frame is queued as {data_packets, ctl, data}.
    int          m_bit = 0;
    logic [9:0]  m_pkt;
    logic [31:0] m_acc = '0;
    logic [3:0]  m_nb = '0;
    logic [43:0] mon_q[$];

    always @(negedge clk) begin
        if (rst) begin
            m_bit = 0; m_acc = '0; m_nb = '0;
        end else if (m_bit == 0) begin
            if (sout === 1'b0) begin m_pkt = '0; m_bit = 1; end
        end else begin
            m_pkt = {m_pkt[8:0], sout};
            m_bit++;
            if (m_bit == 11) begin
                m_bit = 0;
                chk("stop_bit", {63'd0, m_pkt[0]}, 64'd1);
                if (m_pkt[9]) begin
                    mon_q.push_back({m_nb, m_pkt[8:1], m_acc});
                    m_acc = '0; m_nb = '0;
                end else begin
                    m_acc = {m_acc[23:0], m_pkt[8:1]};
                    m_nb++;
                end
            end
        end
    end

    logic [31:0] w_data [6];
    int          acc_edge [6];
    bit          cap [330];

    initial begin
        logic [63:0] bits;
        logic [63:0] v;
        int          k;
        bit          rdy, vld, idle_ok;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctl = '0; in_err = 1'b0;
        in_valid_b = 1'b0; in_data_b = '0; in_ctl_b = '0; in_err_b = 1'b0;
        tick; tick;
        chk("rst_ready_low", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        tick;
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_sout", {63'd0, sout}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_level", {61'd0, fifo_level}, 64'd0);

        // Normal frame with input changes after acceptance
        push_a(32'h12345678, 8'h5A, 1'b0);
        chk("norm_level_t", {61'd0, fifo_level}, 64'd1);
        chk("norm_busy_t", {63'd0, busy}, 64'd0);
        in_data = 32'hDEADBEEF; in_ctl = 8'hFF; in_err = 1'b1;
        tick;
        chk("norm_busy_t1", {63'd0, busy}, 64'd1);
        chk("norm_sout_t1", {63'd0, sout}, 64'd1);
        chk("norm_level_t1", {61'd0, fifo_level}, 64'd0);
        capture(55, 1'b0, bits);
        chk("norm_bits", bits,
            {9'd0, 55'b0_0_00010010_1_0_0_00110100_1_0_0_01010110_1_0_0_01111000_1_0_1_01011010_1});
        chk("norm_busy_last", {63'd0, busy}, 64'd1);
        tick;
        chk("norm_idle_sout", {63'd0, sout}, 64'd1);
        chk("norm_idle_busy", {63'd0, busy}, 64'd0);

        // Error frame
        push_a(32'hFFFFFFFF, 8'hC9, 1'b1);
        tick;
        capture(11, 1'b0, bits);
        chk("err_bits", bits, {53'd0, 11'b0_1_11001001_1});
        tick;
        chk("err_idle_sout", {63'd0, sout}, 64'd1);
        chk("err_idle_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 5; i++) tick;

        // Back-pressure: six words offered continuously
        for (int i = 0; i < 6; i++) w_data[i] = 32'h11223344 + i * 32'h01010101;
        k = 0;
        in_valid = 1'b1; in_err = 1'b0; in_data = w_data[0]; in_ctl = 8'hE0;
        for (int c = 0; c < 334; c++) begin
            rdy = in_ready; vld = in_valid;
            tick;
            if (vld && rdy) begin
                acc_edge[k] = c;
                k++;
                if (k == 6) in_valid = 1'b0;
                else begin in_data = w_data[k]; in_ctl = 8'hE0 + 8'(k); end
            end
            if (c >= 2 && c < 332) cap[c-2] = sout;
            if (c == 4) begin
                chk("full_level", {61'd0, fifo_level}, 64'd4);
                chk("full_ready", {63'd0, in_ready}, 64'd0);
            end
            if (c == 331) chk("bp_busy_last", {63'd0, busy}, 64'd1);
            if (c == 332) begin
                chk("bp_idle_busy", {63'd0, busy}, 64'd0);
                chk("bp_idle_sout", {63'd0, sout}, 64'd1);
            end
        end
        chk("bp_accepted", 64'(k), 64'd6);
        chk("bp_w4_edge", 64'(acc_edge[4]), 64'd4);
        chk("bp_w5_edge", 64'(acc_edge[5]), 64'd57);
        for (int f = 0; f < 6; f++) begin
            v = '0;
            for (int j = 0; j < 55; j++) v = (v << 1) | {63'd0, cap[55*f + j]};
            chk($sformatf("bp_frame%0d", f), v, frame55(w_data[f], 8'hE0 + 8'(f)));
        end

        // Pointer wrap with alternating normal/error words
        mon_q.delete();
        for (int i = 0; i < 10; i++) begin
            chk("wrap_ready", {63'd0, in_ready}, 64'd1);
            push_a(32'hA0B0C0D0 ^ (i * 32'h01010101), 8'h30 + 8'(i), (i % 2) == 1);
            for (int j = 0; j < 29; j++) tick;
        end
        for (int i = 0; i < 2000 && mon_q.size() < 10; i++) tick;
        chk("wrap_count", 64'(mon_q.size()), 64'd10);
        for (int i = 0; i < 10 && i < mon_q.size(); i++) begin
            if (i % 2 == 1) chk("wrap_err", {20'd0, mon_q[i]}, {20'd0, 4'd0, 8'h30 + 8'(i), 32'd0});
            else chk("wrap_norm", {20'd0, mon_q[i]},
                     {20'd0, 4'd4, 8'h30 + 8'(i), 32'hA0B0C0D0 ^ (i * 32'h01010101)});
        end
        for (int i = 0; i < 3; i++) tick;
        chk("wrap_level", {61'd0, fifo_level}, 64'd0);

        // Reset at bit 20 with two words queued
        mon_q.delete();
        push_a(32'h01020304, 8'h11, 1'b0);
        push_a(32'h05060708, 8'h22, 1'b0);
        push_a(32'h090A0B0C, 8'h33, 1'b0);
        for (int i = 0; i < 19; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mrst_sout", {63'd0, sout}, 64'd1);
        chk("mrst_level", {61'd0, fifo_level}, 64'd0);
        chk("mrst_busy", {63'd0, busy}, 64'd0);
        idle_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (sout !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
        end
        chk("mrst_quiet", {63'd0, idle_ok}, 64'd1);
        chk("mrst_no_frames", 64'(mon_q.size()), 64'd0);
        push_a(32'hCAFEF00D, 8'h77, 1'b0);
        for (int i = 0; i < 200 && mon_q.size() < 1; i++) tick;
        chk("mrst_fresh_count", 64'(mon_q.size()), 64'd1);
        if (mon_q.size() > 0)
            chk("mrst_fresh", {20'd0, mon_q[0]}, {20'd0, 4'd4, 8'h77, 32'hCAFEF00D});

        // N_BYTES=1, DEPTH=2 instance
        in_valid_b = 1'b1; in_data_b = 8'hA5; in_ctl_b = 8'h03; in_err_b = 1'b0;
        tick;
        in_valid_b = 1'b0;
        chk("b_level", {62'd0, fifo_level_b}, 64'd1);
        tick;
        chk("b_busy", {63'd0, busy_b}, 64'd1);
        capture(22, 1'b1, bits);
        chk("b_bits", bits, {42'd0, 22'b0_0_10100101_1_0_1_00000011_1});
        tick;
        chk("b_idle_sout", {63'd0, sout_b}, 64'd1);
        chk("b_idle_busy", {63'd0, busy_b}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
